// File: rtl/pc_seq_pkg.sv
// Shared types and default sizes for the program-counter sequencer.
package pc_seq_pkg;

  localparam int D_DEF  = 10;
  localparam int AW_DEF = 4;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_INC  = 2'd1,
    SEL_BR   = 2'd2
  } next_sel_t;

endpackage

// File: rtl/target_table.sv
// Writable branch-target table: one synchronous write port, one combinational read port.
module target_table #(
  parameter int D  = 10,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [D-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [D-1:0]  rdata
);

  localparam int DEPTH = 1 << AW;

  logic [D-1:0] r_mem [DEPTH];

  // Storage: cleared on reset, written on enabled edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, the branch-target table and the
// retired-instruction counter; runs from start until a halt instruction.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  start_pc,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [D-1:0]  cfg_data,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_taken,
  input  logic [AW-1:0] lut_idx,
  input  logic          halt,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] instr_count
);

  state_t        r_state;
  logic [D-1:0]  r_pc;
  logic [CW-1:0] r_cnt;
  logic          r_fetch_valid;
  logic          r_busy;
  logic          r_done;

  next_sel_t     w_sel;
  logic          w_tbl_we;
  logic [D-1:0]  w_target;
  logic [D-1:0]  w_pc_next;
  logic [CW-1:0] w_cnt_inc;

  // The table is frozen while running so a live branch never sees a torn target.
  assign w_tbl_we = cfg_we && (r_state != RUN);

  target_table #(
    .D (D),
    .AW(AW)
  ) u_table (
    .clk  (clk),
    .reset(reset),
    .we   (w_tbl_we),
    .waddr(cfg_addr),
    .wdata(cfg_data),
    .raddr(lut_idx),
    .rdata(w_target)
  );

  // Next-PC source selection in RUN: stall > halt > taken branch > increment.
  always_comb begin
    w_sel = SEL_HOLD;
    if (r_state == RUN) begin
      if (stall) begin
        w_sel = SEL_HOLD;
      end else if (halt) begin
        w_sel = SEL_HOLD;
      end else if (branch_en && branch_taken) begin
        w_sel = SEL_BR;
      end else begin
        w_sel = SEL_INC;
      end
    end else begin
      w_sel = SEL_HOLD;
    end
  end

  // Next-PC mux and saturating counter increment.
  always_comb begin
    w_pc_next = r_pc;
    case (w_sel)
      SEL_HOLD: w_pc_next = r_pc;
      SEL_INC:  w_pc_next = r_pc + {{(D-1){1'b0}}, 1'b1};
      SEL_BR:   w_pc_next = w_target;
      default:  w_pc_next = r_pc;
    endcase
    if (r_cnt == {CW{1'b1}}) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Control FSM with registered PC, counter and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= '0;
      r_cnt         <= '0;
      r_fetch_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE, HALTED: begin
          if (start) begin
            r_state       <= RUN;
            r_pc          <= start_pc;
            r_cnt         <= '0;
            r_fetch_valid <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
          end
        end
        RUN: begin
          r_pc <= w_pc_next;
          if (!stall) begin
            r_cnt <= w_cnt_inc;
            if (halt) begin
              r_state       <= HALTED;
              r_fetch_valid <= 1'b0;
              r_busy        <= 1'b0;
              r_done        <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_fetch_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_done        <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr    = r_pc;
  assign instr_count = r_cnt;
  assign fetch_valid = r_fetch_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (main CW=16 instance plus a
// CW=4 instance sharing the same stimulus for counter saturation).
module tb_pc_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] start_pc;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [9:0] cfg_data;
  logic       stall;
  logic       branch_en;
  logic       branch_taken;
  logic [3:0] lut_idx;
  logic       halt;

  logic [9:0]  prog_ctr;
  logic        fetch_valid;
  logic        busy;
  logic        done;
  logic [15:0] instr_count;

  logic [9:0]  s_prog_ctr;
  logic        s_fetch_valid;
  logic        s_busy;
  logic        s_done;
  logic [3:0]  s_instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.D(10), .AW(4), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .stall(stall), .branch_en(branch_en), .branch_taken(branch_taken),
    .lut_idx(lut_idx), .halt(halt),
    .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .busy(busy),
    .done(done), .instr_count(instr_count)
  );

  pc_sequencer #(.D(10), .AW(4), .CW(4)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .stall(stall), .branch_en(branch_en), .branch_taken(branch_taken),
    .lut_idx(lut_idx), .halt(halt),
    .prog_ctr(s_prog_ctr), .fetch_valid(s_fetch_valid), .busy(s_busy),
    .done(s_done), .instr_count(s_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int pc, input int cnt,
                             input logic fv, input logic bz, input logic dn);
    check({tag, ".pc"},   32'(prog_ctr),    32'(pc));
    check({tag, ".cnt"},  32'(instr_count), 32'(cnt));
    check({tag, ".fv"},   32'(fetch_valid), 32'(fv));
    check({tag, ".busy"}, 32'(busy),        32'(bz));
    check({tag, ".done"}, 32'(done),        32'(dn));
  endtask

  task automatic do_start(input int pc);
    start    = 1'b1;
    start_pc = 10'(pc);
    tick();
    start    = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = 4'(addr);
    cfg_data = 10'(data);
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic take_branch(input int idx, input logic taken);
    branch_en    = 1'b1;
    branch_taken = taken;
    lut_idx      = 4'(idx);
    tick();
    branch_en    = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_pc = 10'd0;
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 10'd0;
    stall = 1'b0; branch_en = 1'b0; branch_taken = 1'b0;
    lut_idx = 4'd0; halt = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_state("por", 0, 0, 1'b0, 1'b0, 1'b0);

    // Test 1: program an entry, run, then reset mid-run.
    cfg_write(5, 77);
    do_start(100);
    check_state("run_start", 100, 0, 1'b1, 1'b1, 1'b0);
    tick();
    check("run_inc.pc", 32'(prog_ctr), 32'd101);
    reset = 1'b1;
    #1;
    check("async_reset.pc", 32'(prog_ctr), 32'd0);
    tick(); tick();
    reset = 1'b0;
    check_state("mid_reset", 0, 0, 1'b0, 1'b0, 1'b0);
    do_start(30);
    take_branch(5, 1'b1);
    check("tbl5_cleared", 32'(prog_ctr), 32'd0);
    do_halt();
    check_state("halt_after_clear", 0, 2, 1'b0, 1'b0, 1'b1);

    // Test 2: sequential run across the PC wrap.
    do_start(1021);
    check_state("wrap0", 1021, 0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_state($sformatf("wrap%0d", k), (1021 + k) % 1024, k, 1'b1, 1'b1, 1'b0);
    end
    do_halt();
    check_state("wrap_halt", 1, 5, 1'b0, 1'b0, 1'b1);

    // Test 3: table-indexed branch.
    cfg_write(3, 110);
    cfg_write(9, 20);
    do_start(0);
    tick(); tick();
    check("pre_branch.pc", 32'(prog_ctr), 32'd2);
    take_branch(3, 1'b1);
    check_state("br_taken", 110, 3, 1'b1, 1'b1, 1'b0);
    take_branch(3, 1'b0);
    check_state("br_not_taken", 111, 4, 1'b1, 1'b1, 1'b0);

    // Test 4: stall beats branch, halt beats branch.
    stall = 1'b1;
    take_branch(9, 1'b1);
    stall = 1'b0;
    check_state("stall_hold", 111, 4, 1'b1, 1'b1, 1'b0);
    take_branch(9, 1'b1);
    check_state("after_stall", 20, 5, 1'b1, 1'b1, 1'b0);
    repeat (24) tick();
    check_state("at44", 44, 29, 1'b1, 1'b1, 1'b0);
    halt = 1'b1;
    take_branch(3, 1'b1);
    halt = 1'b0;
    check_state("halt_vs_branch", 44, 30, 1'b0, 1'b0, 1'b1);
    tick();
    check("halted_hold.pc", 32'(prog_ctr), 32'd44);

    // Test 5: config writes ignored in RUN, accepted in HALTED and with start.
    do_start(50);
    cfg_write(3, 500);
    do_halt();
    do_start(60);
    take_branch(3, 1'b1);
    check("gated_write", 32'(prog_ctr), 32'd110);
    do_halt();
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 10'd500;
    do_start(70);
    cfg_we = 1'b0;
    check("start_with_write.pc", 32'(prog_ctr), 32'd70);
    take_branch(3, 1'b1);
    check("halted_write", 32'(prog_ctr), 32'd500);
    do_halt();

    // Test 6: counter saturation on the CW=4 instance, then restart.
    do_start(0);
    repeat (15) tick();
    check("sat15.cnt", 32'(s_instr_count), 32'd15);
    repeat (5) tick();
    check("sat20.cnt", 32'(s_instr_count), 32'd15);
    check("sat20.pc", 32'(s_prog_ctr), 32'd20);
    check("wide20.cnt", 32'(instr_count), 32'd20);
    do_halt();
    check("sat_halt.cnt", 32'(s_instr_count), 32'd15);
    check("sat_halt.done", 32'(s_done), 32'd1);
    check("wide_halt.cnt", 32'(instr_count), 32'd21);
    do_start(7);
    check("restart.s_cnt", 32'(s_instr_count), 32'd0);
    check("restart.s_pc", 32'(s_prog_ctr), 32'd7);
    check("restart.s_busy", 32'(s_busy), 32'd1);
    check_state("restart", 7, 0, 1'b1, 1'b1, 1'b0);

    // Start while running is ignored.
    do_start(200);
    check_state("start_in_run", 8, 1, 1'b1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
